// File: rtl/volume_ctrl.sv
// volume_ctrl - push-button volume stage of the MP3 player.
//
// Turns two raw, bouncing push-buttons into a saturating attenuation level
// (0 = loudest, MAX_LEVEL = quietest) with hold-to-repeat. It also keeps a
// codec volume word that is offered to the SCI writer over a req/ack handshake.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous, active-low reset
//   btn_up     raw "louder" button, active-high, asynchronous to clk
//   btn_down   raw "quieter" button, active-high, asynchronous to clk
//   vol_level  current attenuation level (registered, drives the LED bar)
//   vol_word   codec volume word {att, att}, att = vol_level * ATT_STEP
//   vol_req    codec update request, held until acknowledged
//   vol_ack    one-cycle acknowledge from the SCI writer
module volume_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000,
  parameter int MAX_LEVEL       = 8,
  parameter int INIT_LEVEL      = 4,
  parameter int ATT_STEP        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [4:0]  vol_level,
  output logic [15:0] vol_word,
  output logic        vol_req,
  input  logic        vol_ack
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = ($clog2(RPT_MAX) > 26) ? $clog2(RPT_MAX) : 26;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [4:0]       MAX_LVL     = 5'(MAX_LEVEL);
  localparam logic [4:0]       INIT_LVL    = 5'(INIT_LEVEL);
  localparam logic [7:0]       INIT_ATT    = 8'(INIT_LEVEL * ATT_STEP);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic             deb_up;
  logic             deb_dn;
  logic [DB_W-1:0]  cnt_up;
  logic [DB_W-1:0]  cnt_dn;

  state_t           state;
  logic             dir_dn;
  logic [RPT_W-1:0] rpt_cnt;

  logic             up_act;
  logic             dn_act;
  logic             active;
  logic             step_req;
  logic             step_dn;
  logic [4:0]       next_level;
  logic [7:0]       next_att;
  logic             changed;

  // Two-flop synchronizers; bit 0 is the up button, bit 1 the down button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 2'b00;
      sync_b <= 2'b00;
    end else begin
      sync_a <= {btn_down, btn_up};
      sync_b <= sync_a;
    end
  end

  // Debounce: the state only flips after the synchronized input has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_up <= '0;
      deb_up <= 1'b0;
    end else if (sync_b[0] == deb_up) begin
      cnt_up <= '0;
    end else if (cnt_up == DB_LAST) begin
      cnt_up <= '0;
      deb_up <= ~deb_up;
    end else begin
      cnt_up <= cnt_up + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_dn <= '0;
      deb_dn <= 1'b0;
    end else if (sync_b[1] == deb_dn) begin
      cnt_dn <= '0;
    end else if (cnt_dn == DB_LAST) begin
      cnt_dn <= '0;
      deb_dn <= ~deb_dn;
    end else begin
      cnt_dn <= cnt_dn + 1'b1;
    end
  end

  // Pressing both buttons at once counts as no press at all.
  assign up_act = deb_up & ~deb_dn;
  assign dn_act = deb_dn & ~deb_up;
  assign active = dir_dn ? dn_act : up_act;

  // Decide whether this cycle issues a step and where the level lands.
  // A step that would leave 0..MAX_LEVEL is swallowed and is not a change.
  always_comb begin
    step_req   = 1'b0;
    step_dn    = 1'b0;
    next_level = vol_level;
    case (state)
      IDLE: begin
        if (up_act || dn_act) begin
          step_req = 1'b1;
          step_dn  = dn_act;
        end
      end
      default: begin
        if (active && rpt_cnt == '0) begin
          step_req = 1'b1;
          step_dn  = dir_dn;
        end
      end
    endcase
    if (step_req) begin
      if (step_dn) begin
        if (vol_level < MAX_LVL) next_level = vol_level + 1'b1;
      end else begin
        if (vol_level != 5'd0) next_level = vol_level - 1'b1;
      end
    end
    changed  = (next_level != vol_level);
    next_att = 8'(int'(next_level) * ATT_STEP);
  end

  // Repeat FSM plus the registered level, codec word and request.
  // HOLD and REPEAT share behaviour; only the reload value after a step
  // differs, and that is always REPEAT_PERIOD once the first delay expired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir_dn    <= 1'b0;
      rpt_cnt   <= '0;
      vol_level <= INIT_LVL;
      vol_word  <= {INIT_ATT, INIT_ATT};
      vol_req   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (up_act || dn_act) begin
            dir_dn  <= dn_act;
            rpt_cnt <= DELAY_LOAD;
            state   <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!active) begin
            state <= IDLE;
          end else if (rpt_cnt == '0) begin
            rpt_cnt <= PERIOD_LOAD;
            state   <= REPEAT;
          end else begin
            rpt_cnt <= rpt_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      vol_level <= next_level;
      // A change always wins over an ack so no update is ever lost.
      if (changed) begin
        vol_word <= {next_att, next_att};
        vol_req  <= 1'b1;
      end else if (vol_ack) begin
        vol_req <= 1'b0;
      end
    end
  end

endmodule
